// File: rtl/fxu_writeback.sv
// fxu_writeback: writeback stage after the fixed-point unit.
// Merges FX results and load results onto one GPR write port, commits CR
// field / whole-CR writes and owns the architectural XER SO/OV/CA bits.
// FX results wait in a small circular FIFO because loads own the GPR port.
//
// Handshake: an FX entry transfers on a cycle where fx_valid and fx_ready
// are both high and flush is low. fx_ready depends on the buffered count
// only (never on a same-cycle pop), so the FX unit sees a stable ready.
// Loads have no handshake; they are never stalled.
module fxu_writeback #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        fx_valid,
   output logic        fx_ready,
   input  logic [31:0] fx_res_a,
   input  logic [31:0] fx_res_b,
   input  logic [3:0]  fx_crf,
   input  logic        fx_cout,
   input  logic        fx_ov,
   input  logic        fx_gpr_we,
   input  logic [4:0]  fx_gpr_addr,
   input  logic        fx_crf_we,
   input  logic [2:0]  fx_crf_sel,
   input  logic        fx_cr_all_we,
   input  logic        fx_ov_we,
   input  logic        fx_ca_we,
   input  logic        fx_xer_load,
   input  logic        ls_valid,
   input  logic [4:0]  ls_addr,
   input  logic [31:0] ls_data,
   output logic        gpr_we,
   output logic [4:0]  gpr_addr,
   output logic [31:0] gpr_data,
   output logic [7:0]  cr_we,
   output logic [31:0] cr_data,
   output logic        so,
   output logic        ov,
   output logic        ca,
   output logic        waw_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [31:0] res_a;
      logic [31:0] res_b;
      logic [3:0]  crf;
      logic        cout;
      logic        ov;
      logic        gpr_we;
      logic [4:0]  gpr_addr;
      logic        crf_we;
      logic [2:0]  crf_sel;
      logic        cr_all_we;
      logic        ov_we;
      logic        ca_we;
      logic        xer_load;
   } entry_t;

   entry_t        mem [FIFO_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [PW-1:0] slot;

   entry_t        in_e;
   entry_t        sel_e;
   logic          empty;
   logic          push;
   logic          bypass;
   logic          store;
   logic          pop;
   logic          fx_commit;
   logic          waw_hit;
   logic [3:0]    cr_field;
   logic [7:0]    cr_we_d;
   logic [31:0]   cr_data_d;

   assign fx_ready  = (count < CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign push      = fx_valid & fx_ready & ~flush;
   // Incoming entry commits straight through only when nothing is ahead of it.
   assign bypass    = push & empty & ~ls_valid;
   assign store     = push & ~bypass;
   assign pop       = ~empty & ~ls_valid & ~flush;
   assign fx_commit = pop | bypass;
   assign sel_e     = empty ? in_e : mem[head];

   // Pack the incoming FX fields into one entry so they are stored atomically.
   always_comb begin
      in_e           = '0;
      in_e.res_a     = fx_res_a;
      in_e.res_b     = fx_res_b;
      in_e.crf       = fx_crf;
      in_e.cout      = fx_cout;
      in_e.ov        = fx_ov;
      in_e.gpr_we    = fx_gpr_we;
      in_e.gpr_addr  = fx_gpr_addr;
      in_e.crf_we    = fx_crf_we;
      in_e.crf_sel   = fx_crf_sel;
      in_e.cr_all_we = fx_cr_all_we;
      in_e.ov_we     = fx_ov_we;
      in_e.ca_we     = fx_ca_we;
      in_e.xer_load  = fx_xer_load;
   end

   // CR write mask/data for the committing entry; single-field SO uses the
   // architectural SO plus this instruction's own overflow.
   always_comb begin
      cr_we_d   = '0;
      cr_data_d = '0;
      cr_field  = {sel_e.crf[3:1], so | (sel_e.ov_we & sel_e.ov)};
      if (sel_e.cr_all_we) begin
         cr_we_d   = 8'hFF;
         cr_data_d = sel_e.res_b;
      end else if (sel_e.crf_we) begin
         cr_we_d   = 8'h80 >> sel_e.crf_sel;
         cr_data_d = 32'(cr_field) << (5'd28 - {sel_e.crf_sel, 2'b00});
      end
   end

   // Detect a load targeting the same GPR as a live buffered or accepted FX entry.
   always_comb begin
      waw_hit = 1'b0;
      slot    = '0;
      if (ls_valid && !flush) begin
         if (push && fx_gpr_we && (fx_gpr_addr == ls_addr)) waw_hit = 1'b1;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (int'(head) + i >= FIFO_DEPTH) slot = PW'(int'(head) + i - FIFO_DEPTH);
            else                              slot = PW'(int'(head) + i);
            if ((i < int'(count)) && mem[slot].gpr_we && (mem[slot].gpr_addr == ls_addr))
               waw_hit = 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (store) mem[tail] <= in_e;
   end

   // FIFO pointers and occupancy; flush empties the buffer in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (store) tail <= (tail == PW'(FIFO_DEPTH - 1)) ? '0 : tail + 1'b1;
         if (pop)   head <= (head == PW'(FIFO_DEPTH - 1)) ? '0 : head + 1'b1;
         if (store && !pop)      count <= count + 1'b1;
         else if (!store && pop) count <= count - 1'b1;
      end
   end

   // Registered write ports and XER; a load owns the GPR port, else the FX commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gpr_we   <= 1'b0;
         gpr_addr <= '0;
         gpr_data <= '0;
         cr_we    <= '0;
         cr_data  <= '0;
         so       <= 1'b0;
         ov       <= 1'b0;
         ca       <= 1'b0;
         waw_err  <= 1'b0;
      end else begin
         waw_err <= waw_hit;
         gpr_we  <= 1'b0;
         cr_we   <= '0;
         if (ls_valid) begin
            gpr_we   <= 1'b1;
            gpr_addr <= ls_addr;
            gpr_data <= ls_data;
         end else if (fx_commit) begin
            gpr_we <= sel_e.gpr_we;
            if (sel_e.gpr_we) begin
               gpr_addr <= sel_e.gpr_addr;
               gpr_data <= sel_e.res_a;
            end
            cr_we <= cr_we_d;
            if (cr_we_d != '0) cr_data <= cr_data_d;
            if (sel_e.xer_load) begin
               so <= sel_e.res_a[31];
               ov <= sel_e.res_a[30];
               ca <= sel_e.res_a[29];
            end else begin
               if (sel_e.ov_we) begin
                  ov <= sel_e.ov;
                  so <= so | sel_e.ov;
               end
               if (sel_e.ca_we) ca <= sel_e.cout;
            end
         end
      end
   end

endmodule

// File: tb/tb_fxu_writeback.sv
// Testbench for fxu_writeback: directed scenarios with literal expectations
// followed by randomized traffic checked against a queue-based model.
module tb_fxu_writeback;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] res_a;
      logic [31:0] res_b;
      logic [3:0]  crf;
      logic        cout;
      logic        ov;
      logic        gpr_we;
      logic [4:0]  gpr_addr;
      logic        crf_we;
      logic [2:0]  crf_sel;
      logic        cr_all_we;
      logic        ov_we;
      logic        ca_we;
      logic        xer_load;
   } fx_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        flush, fx_valid, fx_ready;
   logic [31:0] fx_res_a, fx_res_b;
   logic [3:0]  fx_crf;
   logic        fx_cout, fx_ov, fx_gpr_we;
   logic [4:0]  fx_gpr_addr;
   logic        fx_crf_we;
   logic [2:0]  fx_crf_sel;
   logic        fx_cr_all_we, fx_ov_we, fx_ca_we, fx_xer_load;
   logic        ls_valid;
   logic [4:0]  ls_addr;
   logic [31:0] ls_data;
   logic        gpr_we;
   logic [4:0]  gpr_addr;
   logic [31:0] gpr_data;
   logic [7:0]  cr_we;
   logic [31:0] cr_data;
   logic        so, ov, ca, waw_err;

   fxu_writeback #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .fx_valid(fx_valid), .fx_ready(fx_ready),
      .fx_res_a(fx_res_a), .fx_res_b(fx_res_b), .fx_crf(fx_crf),
      .fx_cout(fx_cout), .fx_ov(fx_ov),
      .fx_gpr_we(fx_gpr_we), .fx_gpr_addr(fx_gpr_addr),
      .fx_crf_we(fx_crf_we), .fx_crf_sel(fx_crf_sel),
      .fx_cr_all_we(fx_cr_all_we), .fx_ov_we(fx_ov_we), .fx_ca_we(fx_ca_we),
      .fx_xer_load(fx_xer_load),
      .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_data(ls_data),
      .gpr_we(gpr_we), .gpr_addr(gpr_addr), .gpr_data(gpr_data),
      .cr_we(cr_we), .cr_data(cr_data),
      .so(so), .ov(ov), .ca(ca), .waw_err(waw_err)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;

   fx_t  m_q[$];
   logic m_so, m_ov, m_ca;

   logic        nxt_gpr_we, exp_gpr_we;
   logic [4:0]  nxt_gpr_addr, exp_gpr_addr;
   logic [31:0] nxt_gpr_data, exp_gpr_data;
   logic [7:0]  nxt_cr_we, exp_cr_we;
   logic [31:0] nxt_cr_data, exp_cr_data;
   logic        nxt_so, nxt_ov, nxt_ca, exp_so, exp_ov, exp_ca;
   logic        nxt_waw, exp_waw;
   logic        nxt_ready, exp_ready;
   logic        chk_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_commit(input fx_t e);
      int         s;
      logic [3:0] fld;
      if (e.gpr_we) begin
         nxt_gpr_we   = 1'b1;
         nxt_gpr_addr = e.gpr_addr;
         nxt_gpr_data = e.res_a;
      end
      if (e.cr_all_we) begin
         nxt_cr_we   = 8'hFF;
         nxt_cr_data = e.res_b;
      end else if (e.crf_we) begin
         s           = int'(e.crf_sel);
         fld         = {e.crf[3:1], m_so | (e.ov_we & e.ov)};
         nxt_cr_we   = 8'(32'd1 << (7 - s));
         nxt_cr_data = 32'(fld) << (4 * (7 - s));
      end
      if (e.xer_load) begin
         m_so = e.res_a[31];
         m_ov = e.res_a[30];
         m_ca = e.res_a[29];
      end else begin
         if (e.ov_we) begin
            m_ov = e.ov;
            m_so = m_so | e.ov;
         end
         if (e.ca_we) m_ca = e.cout;
      end
   endtask

   // Computes what the outputs must be after the coming edge from the current inputs.
   task automatic model_step();
      fx_t  in_e, e;
      logic acc, com;
      in_e = '{fx_res_a, fx_res_b, fx_crf, fx_cout, fx_ov, fx_gpr_we, fx_gpr_addr,
               fx_crf_we, fx_crf_sel, fx_cr_all_we, fx_ov_we, fx_ca_we, fx_xer_load};
      e    = '0;
      acc  = fx_valid && (m_q.size() < DEPTH) && !flush;
      com  = 1'b0;
      nxt_waw = 1'b0;
      if (ls_valid && !flush) begin
         foreach (m_q[i]) if (m_q[i].gpr_we && (m_q[i].gpr_addr == ls_addr)) nxt_waw = 1'b1;
         if (acc && in_e.gpr_we && (in_e.gpr_addr == ls_addr)) nxt_waw = 1'b1;
      end
      nxt_gpr_we = 1'b0;
      nxt_cr_we  = 8'h00;
      if (ls_valid) begin
         nxt_gpr_we   = 1'b1;
         nxt_gpr_addr = ls_addr;
         nxt_gpr_data = ls_data;
      end else if (!flush && m_q.size() > 0) begin
         e   = m_q.pop_front();
         com = 1'b1;
      end else if (acc) begin
         e   = in_e;
         com = 1'b1;
         acc = 1'b0;
      end
      if (acc) m_q.push_back(in_e);
      if (flush) m_q.delete();
      if (com) model_commit(e);
      nxt_so    = m_so;
      nxt_ov    = m_ov;
      nxt_ca    = m_ca;
      nxt_ready = (m_q.size() < DEPTH);
   endtask

   task automatic model_clear();
      m_q.delete();
      m_so = 1'b0; m_ov = 1'b0; m_ca = 1'b0;
      exp_gpr_we = 1'b0; exp_gpr_addr = '0; exp_gpr_data = '0;
      exp_cr_we = '0; exp_cr_data = '0;
      exp_so = 1'b0; exp_ov = 1'b0; exp_ca = 1'b0;
      exp_waw = 1'b0; exp_ready = 1'b1;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("gpr_we", 32'(gpr_we), 32'(exp_gpr_we));
         if (exp_gpr_we) begin
            chk("gpr_addr", 32'(gpr_addr), 32'(exp_gpr_addr));
            chk("gpr_data", gpr_data, exp_gpr_data);
         end
         chk("cr_we", 32'(cr_we), 32'(exp_cr_we));
         if (exp_cr_we != 8'h00) chk("cr_data", cr_data, exp_cr_data);
         chk("xer", 32'({so, ov, ca}), 32'({exp_so, exp_ov, exp_ca}));
         chk("waw_err", 32'(waw_err), 32'(exp_waw));
         chk("fx_ready", 32'(fx_ready), 32'(exp_ready));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_in();
      flush = 1'b0; fx_valid = 1'b0;
      fx_res_a = '0; fx_res_b = '0; fx_crf = '0; fx_cout = 1'b0; fx_ov = 1'b0;
      fx_gpr_we = 1'b0; fx_gpr_addr = '0; fx_crf_we = 1'b0; fx_crf_sel = '0;
      fx_cr_all_we = 1'b0; fx_ov_we = 1'b0; fx_ca_we = 1'b0; fx_xer_load = 1'b0;
      ls_valid = 1'b0; ls_addr = '0; ls_data = '0;
   endtask

   // One clock: model predicts, edge happens, expectation goes live; returns at edge+1.
   task automatic tick();
      model_step();
      @(posedge clk);
      exp_gpr_we = nxt_gpr_we; exp_gpr_addr = nxt_gpr_addr; exp_gpr_data = nxt_gpr_data;
      exp_cr_we = nxt_cr_we; exp_cr_data = nxt_cr_data;
      exp_so = nxt_so; exp_ov = nxt_ov; exp_ca = nxt_ca;
      exp_waw = nxt_waw; exp_ready = nxt_ready;
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_in();
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic fx_gpr(input logic [4:0] a, input logic [31:0] d);
      fx_valid = 1'b1; fx_gpr_we = 1'b1; fx_gpr_addr = a; fx_res_a = d;
   endtask

   task automatic load(input logic [4:0] a, input logic [31:0] d);
      ls_valid = 1'b1; ls_addr = a; ls_data = d;
   endtask

   task automatic rand_in(input int ls_pct);
      ls_valid     = ($urandom_range(0, 99) < ls_pct);
      ls_addr      = 5'($urandom_range(0, 31));
      ls_data      = $urandom();
      flush        = ($urandom_range(0, 99) < 5);
      fx_valid     = ($urandom_range(0, 99) < 65);
      fx_res_a     = $urandom();
      fx_res_b     = $urandom();
      fx_crf       = 4'($urandom_range(0, 15));
      fx_cout      = 1'($urandom_range(0, 1));
      fx_ov        = 1'($urandom_range(0, 1));
      fx_gpr_we    = ($urandom_range(0, 3) != 0);
      fx_gpr_addr  = 5'($urandom_range(0, 31));
      fx_crf_we    = 1'($urandom_range(0, 1));
      fx_crf_sel   = 3'($urandom_range(0, 7));
      fx_cr_all_we = ($urandom_range(0, 7) == 0);
      fx_ov_we     = 1'($urandom_range(0, 1));
      fx_ca_we     = 1'($urandom_range(0, 1));
      fx_xer_load  = ($urandom_range(0, 9) == 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      chk_en = 1'b1;
      do_reset();

      // FX add straight through an empty FIFO.
      fx_gpr(5'd3, 32'h5); fx_crf_we = 1'b1; fx_crf_sel = 3'd0; fx_crf = 4'b0100;
      tick(); clear_in();
      chk("t1_gpr_we", 32'(gpr_we), 32'd1);
      chk("t1_gpr_addr", 32'(gpr_addr), 32'd3);
      chk("t1_gpr_data", gpr_data, 32'h5);
      chk("t1_cr_we", 32'(cr_we), 32'h80);
      chk("t1_cr_field", 32'(cr_data[31:28]), 32'b0100);

      // Load and FX together: load first, FX one cycle later.
      load(5'd4, 32'hDEADBEEF); fx_gpr(5'd5, 32'h11);
      tick(); clear_in();
      chk("t2_load_addr", 32'(gpr_addr), 32'd4);
      chk("t2_load_data", gpr_data, 32'hDEADBEEF);
      tick();
      chk("t2_fx_addr", 32'(gpr_addr), 32'd5);
      chk("t2_fx_data", gpr_data, 32'h11);

      // Four load cycles with FX offered every cycle: FIFO fills at two.
      for (int k = 0; k < 4; k++) begin
         load(5'(20 + k), 32'(k));
         fx_gpr(5'(8 + k), 32'h100 + 32'(k));
         tick();
         if (k == 1) chk("t3_ready_low", 32'(fx_ready), 32'd0);
      end
      clear_in();
      chk("t3_last_load", 32'(gpr_addr), 32'd23);
      tick();
      chk("t3_fx0_addr", 32'(gpr_addr), 32'd8);
      chk("t3_fx0_data", gpr_data, 32'h100);
      tick();
      chk("t3_fx1_addr", 32'(gpr_addr), 32'd9);
      chk("t3_fx1_data", gpr_data, 32'h101);
      tick();
      chk("t3_no_dup", 32'(gpr_we), 32'd0);

      // Sticky SO across two overflow updates, seen in the second CR field.
      fx_valid = 1'b1; fx_ov_we = 1'b1; fx_ov = 1'b1; fx_crf_we = 1'b1; fx_crf_sel = 3'd2;
      tick();
      chk("t4_so_set", 32'({so, ov}), 32'b11);
      chk("t4_cr1", cr_data, 32'h0010_0000);
      fx_ov = 1'b0; fx_crf = 4'b1000;
      tick(); clear_in();
      chk("t4_so_ov", 32'({so, ov}), 32'b10);
      chk("t4_cr_we", 32'(cr_we), 32'h20);
      chk("t4_cr2", cr_data, 32'h0090_0000);

      // mtxer.
      fx_valid = 1'b1; fx_xer_load = 1'b1; fx_res_a = 32'h2000_0000;
      tick(); clear_in();
      chk("t5_xer", 32'({so, ov, ca}), 32'b001);

      // Two buffered entries dropped by a flush that arrives with a load.
      for (int k = 0; k < 2; k++) begin
         load(5'(24 + 2 * k), 32'hA0 + 32'(k));
         fx_gpr(5'(12 + k), 32'hB0 + 32'(k)); fx_ov_we = 1'b1; fx_ov = 1'b1;
         tick();
      end
      clear_in();
      flush = 1'b1; load(5'd25, 32'hC0);
      tick(); clear_in();
      chk("t6_load_addr", 32'(gpr_addr), 32'd25);
      chk("t6_ready", 32'(fx_ready), 32'd1);
      chk("t6_xer", 32'({so, ov, ca}), 32'b001);
      tick();
      chk("t6_nothing", 32'(gpr_we), 32'd0);

      // Flush without a load suppresses the head commit.
      load(5'd26, 32'hD0); fx_gpr(5'd14, 32'hE0); fx_ov_we = 1'b1; fx_ov = 1'b1;
      tick(); clear_in();
      flush = 1'b1;
      tick(); clear_in();
      chk("t6b_suppress", 32'(gpr_we), 32'd0);
      chk("t6b_xer", 32'({so, ov, ca}), 32'b001);

      // Same target for load and FX flags waw_err, both writes still happen.
      load(5'd7, 32'h77); fx_gpr(5'd7, 32'h7);
      tick(); clear_in();
      chk("t7_waw", 32'(waw_err), 32'd1);
      chk("t7_load", gpr_data, 32'h77);
      tick();
      chk("t7_fx", gpr_data, 32'h7);
      chk("t7_waw_clear", 32'(waw_err), 32'd0);

      // Reset while entries are buffered.
      for (int k = 0; k < 2; k++) begin
         load(5'(16 + k), 32'hF0 + 32'(k));
         fx_gpr(5'(1 + k), 32'h1 + 32'(k)); fx_crf_we = 1'b1;
         tick();
      end
      reset_n = 1'b0;
      clear_in();
      model_clear();
      #1;
      chk("t8_gpr", 32'({gpr_we, gpr_addr}), 32'd0);
      chk("t8_gpr_data", gpr_data, 32'd0);
      chk("t8_cr", 32'(cr_we), 32'd0);
      chk("t8_cr_data", cr_data, 32'd0);
      chk("t8_xer_waw", 32'({so, ov, ca, waw_err}), 32'd0);
      chk("t8_ready", 32'(fx_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      chk("t8_no_commit", 32'(gpr_we), 32'd0);

      // Randomized traffic, alternating light and heavy load pressure.
      for (int c = 0; c < 800; c++) begin
         rand_in(((c / 100) % 2 == 1) ? 85 : 30);
         tick();
      end
      clear_in();
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
